// File: rtl/two_of_five_rx.sv
// Serial 2-of-5 frame receiver feeding the 7-segment decoders.
// Holds the last valid code word, blanks while none is held, and counts rejected frames.
module two_of_five_rx #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned ERR_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic [4:0]       code_out,
  output logic             code_strobe,
  output logic             err_strobe,
  output logic             blank,
  output logic [ERR_W-1:0] err_count,
  output logic             busy
);

  localparam int unsigned GAP_W = 8;
  localparam int unsigned CNT_W = 3;
  localparam logic [GAP_W-1:0] GAP_LIM = GAP_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(4);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [3:0]       shift_q, shift_d;
  logic [4:0]       code_q, code_d;
  logic             code_stb_q, code_stb_d;
  logic             err_stb_q, err_stb_d;
  logic             blank_q, blank_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic [4:0] word_c;
  logic [2:0] ones_c;
  logic       reject_c;

  // Candidate word if the current bit completes the frame
  always_comb begin
    word_c = {shift_q, bit_in};
    ones_c = '0;
    for (int i = 0; i < 5; i++) begin
      ones_c = ones_c + 3'(word_c[i]);
    end
  end

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    shift_d    = shift_q;
    code_d     = code_q;
    code_stb_d = 1'b0;
    err_stb_d  = 1'b0;
    blank_d    = blank_q;
    err_cnt_d  = err_cnt_q;
    reject_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bit_valid && (start || armed_q)) begin
          shift_d = {3'b000, bit_in};
          cnt_d   = CNT_W'(1);
          gap_d   = '0;
          armed_d = 1'b0;
          state_d = ST_SHIFT;
        end else if (start) begin
          armed_d = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (start) begin
          // Abort the partial frame silently and restart the bit count
          gap_d = '0;
          if (bit_valid) begin
            shift_d = {3'b000, bit_in};
            cnt_d   = CNT_W'(1);
          end else begin
            shift_d = '0;
            cnt_d   = '0;
          end
        end else if (bit_valid) begin
          gap_d = '0;
          if (cnt_q == LAST_BIT) begin
            state_d = ST_IDLE;
            if (ones_c == 3'd2) begin
              code_d     = word_c;
              code_stb_d = 1'b1;
              blank_d    = 1'b0;
            end else begin
              reject_c = 1'b1;
              blank_d  = 1'b1;
            end
          end else begin
            shift_d = word_c[3:0];
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end else if (gap_q == GAP_LIM) begin
          reject_c = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (reject_c) begin
      err_stb_d = 1'b1;
      if (err_cnt_q != ERR_MAX) begin
        err_cnt_d = err_cnt_q + ERR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      armed_q    <= 1'b0;
      cnt_q      <= '0;
      gap_q      <= '0;
      shift_q    <= '0;
      code_q     <= '0;
      code_stb_q <= 1'b0;
      err_stb_q  <= 1'b0;
      blank_q    <= 1'b1;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      shift_q    <= shift_d;
      code_q     <= code_d;
      code_stb_q <= code_stb_d;
      err_stb_q  <= err_stb_d;
      blank_q    <= blank_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign code_out    = code_q;
  assign code_strobe = code_stb_q;
  assign err_strobe  = err_stb_q;
  assign blank       = blank_q;
  assign err_count   = err_cnt_q;
  assign busy        = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_two_of_five_rx.sv
// Bench for two_of_five_rx: frame table, directed corner sequences and random
// stimulus compared every cycle against a queue-based frame model.
module tb_two_of_five_rx;

  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned ERR_W   = 4;
  localparam int          ERR_MAX = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             bit_valid = 1'b0;
  logic             bit_in = 1'b0;
  logic [4:0]       code_out;
  logic             code_strobe;
  logic             err_strobe;
  logic             blank;
  logic [ERR_W-1:0] err_count;
  logic             busy;

  two_of_five_rx #(.TIMEOUT(TIMEOUT), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid), .bit_in(bit_in),
    .code_out(code_out), .code_strobe(code_strobe), .err_strobe(err_strobe),
    .blank(blank), .err_count(err_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Frame-level model: bits collected in a queue, idle cycles counted
  bit         m_in = 0;
  bit         m_armed = 0;
  int         m_idle = 0;
  bit         m_q[$];
  logic [4:0] m_code = '0;
  bit         m_cs = 0;
  bit         m_es = 0;
  bit         m_blank = 1;
  int         m_err = 0;

  function automatic void m_reject();
    m_es = 1;
    if (m_err < ERR_MAX) m_err++;
  endfunction

  function automatic void model_step(bit r, bit s, bit v, bit b);
    int w;
    int ones;
    if (r) begin
      m_in = 0; m_armed = 0; m_idle = 0; m_q.delete();
      m_code = '0; m_cs = 0; m_es = 0; m_blank = 1; m_err = 0;
      return;
    end
    m_cs = 0;
    m_es = 0;
    if (!m_in) begin
      if (v && (s || m_armed)) begin
        m_q.delete(); m_q.push_back(b);
        m_in = 1; m_idle = 0; m_armed = 0;
      end else if (s) begin
        m_armed = 1;
      end
    end else if (s) begin
      m_q.delete();
      m_idle = 0;
      if (v) m_q.push_back(b);
    end else if (v) begin
      m_q.push_back(b);
      m_idle = 0;
      if (m_q.size() == 5) begin
        w = 0; ones = 0;
        foreach (m_q[i]) begin
          w = w * 2 + int'(m_q[i]);
          ones += int'(m_q[i]);
        end
        m_in = 0;
        if (ones == 2) begin
          m_code = 5'(w); m_cs = 1; m_blank = 0;
        end else begin
          m_reject(); m_blank = 1;
        end
      end
    end else if (m_idle == int'(TIMEOUT)) begin
      m_reject();
      m_in = 0;
    end else begin
      m_idle++;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [31:0] act;
    logic [31:0] exp;
    act = 32'({code_out, code_strobe, err_strobe, blank, err_count, busy});
    exp = 32'({m_code, m_cs, m_es, m_blank, ERR_W'(m_err), m_in});
    chk("model{code,cs,es,blank,errcnt,busy}", act, exp);
  endtask

  task automatic cycle(input bit r, input bit s, input bit v, input bit b);
    rst = r; start = s; bit_valid = v; bit_in = b;
    model_step(r, s, v, b);
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic send_frame(input logic [4:0] w);
    for (int i = 0; i < 5; i++) cycle(1'b0, i == 0, 1'b1, w[4-i]);
  endtask

  typedef struct {
    logic [4:0] w;
    bit         ok;
  } vec_t;

  vec_t       tbl[8];
  logic [4:0] last_ok;
  int         n;
  bit         seen;
  int         pct;

  initial begin
    tbl[0] = '{5'b11000, 1'b1};
    tbl[1] = '{5'b01001, 1'b1};
    tbl[2] = '{5'b11100, 1'b0};
    tbl[3] = '{5'b00000, 1'b0};
    tbl[4] = '{5'b00110, 1'b1};
    tbl[5] = '{5'b11111, 1'b0};
    tbl[6] = '{5'b10000, 1'b0};
    tbl[7] = '{5'b10001, 1'b1};

    // Reset then idle
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0);
    chk("reset_code", 32'(code_out), 32'd0);
    chk("reset_blank", 32'(blank), 32'd1);
    chk("reset_errcnt", 32'(err_count), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);

    // Table of back-to-back frames
    last_ok = '0;
    foreach (tbl[k]) begin
      send_frame(tbl[k].w);
      chk("tbl_code_strobe", 32'(code_strobe), 32'(tbl[k].ok));
      chk("tbl_err_strobe", 32'(err_strobe), 32'(!tbl[k].ok));
      chk("tbl_blank", 32'(blank), 32'(!tbl[k].ok));
      if (tbl[k].ok) last_ok = tbl[k].w;
      chk("tbl_code_out", 32'(code_out), 32'(last_ok));
    end
    cycle(0, 0, 0, 0);
    chk("strobe_one_cycle", 32'({code_strobe, err_strobe}), 32'd0);

    // Timeout after two bits, then a valid frame
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 0);
    cycle(0, 0, 1, 1);
    n = 0; seen = 0;
    while (n < 40 && !seen) begin
      cycle(0, 0, 0, 0);
      n++;
      if (err_strobe === 1'b1) seen = 1;
    end
    chk("timeout_idle_cycles", 32'(n), 32'(TIMEOUT + 1));
    chk("timeout_busy", 32'(busy), 32'd0);
    chk("timeout_errcnt", 32'(err_count), 32'd1);
    send_frame(5'b00011);
    chk("after_timeout_code", 32'(code_out), 32'b00011);
    chk("after_timeout_blank", 32'(blank), 32'd0);

    // Error counter saturation
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) send_frame(5'b11111);
    chk("errcnt_saturate", 32'(err_count), 32'(ERR_MAX));

    // Start mid-frame restarts without error
    cycle(1, 0, 0, 0);
    cycle(0, 1, 1, 1);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 1);
    send_frame(5'b10100);
    chk("restart_code", 32'(code_out), 32'b10100);
    chk("restart_strobe", 32'(code_strobe), 32'd1);
    chk("restart_errcnt", 32'(err_count), 32'd0);

    // Armed start: bit 0 arrives a few cycles later
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    chk("armed_code", 32'(code_out), 32'b01100);

    // Reset mid-frame
    cycle(0, 1, 1, 1);
    cycle(0, 0, 1, 1);
    cycle(1, 0, 0, 0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_strobes", 32'({code_strobe, err_strobe}), 32'd0);
    cycle(0, 0, 0, 0);
    chk("midrst_strobes_after", 32'({code_strobe, err_strobe}), 32'd0);

    // Random traffic with varying bit density to hit timeouts
    pct = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) begin
        case ($urandom_range(0, 2))
          0: pct = 3;
          1: pct = 50;
          default: pct = 95;
        endcase
      end
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 99) < pct, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
